// File: rtl/cache_pkg.sv
// Shared constants and the per-port state encoding for the cache read side.
package cache_pkg;

   localparam int DW    = 16;
   localparam int IW    = 5;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INFLIGHT = 2'd1,
      HOLD     = 2'd2
   } port_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: the search starts at ptr and the first requester wins.
module rr_arbiter_4
   import cache_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_any,
   output logic [1:0] next_ptr
);

   logic [1:0] cand;

   // Walk the four positions starting at ptr; the pointer moves past the winner or holds.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      next_ptr  = ptr;
      cand      = '0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr + k[1:0];
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
            next_ptr    = cand + 2'd1;
         end
      end
   end

endmodule

// File: rtl/cache_reader_4.sv
// Read/drain side of the shared PE overflow cache: arbitrates four PE read requests
// onto the single RAM read port, returns words by valid/ready and owns the free mask.
module cache_reader_4
   import cache_pkg::*;
#(
   parameter int Data_Width    = DW,
   parameter int Index_Width   = IW,
   parameter int Address_Width = AW,
   parameter int Depth         = DEPTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                Req_Valid_0,
   input  logic                                Req_Valid_1,
   input  logic                                Req_Valid_2,
   input  logic                                Req_Valid_3,
   input  logic [Address_Width-1:0]            Req_Add_0,
   input  logic [Address_Width-1:0]            Req_Add_1,
   input  logic [Address_Width-1:0]            Req_Add_2,
   input  logic [Address_Width-1:0]            Req_Add_3,
   output logic                                Req_Ready_0,
   output logic                                Req_Ready_1,
   output logic                                Req_Ready_2,
   output logic                                Req_Ready_3,
   output logic                                Rsp_Valid_0,
   output logic                                Rsp_Valid_1,
   output logic                                Rsp_Valid_2,
   output logic                                Rsp_Valid_3,
   output logic [Data_Width-1:0]               Rsp_Data_0,
   output logic [Data_Width-1:0]               Rsp_Data_1,
   output logic [Data_Width-1:0]               Rsp_Data_2,
   output logic [Data_Width-1:0]               Rsp_Data_3,
   output logic [Index_Width-1:0]              Rsp_Index_0,
   output logic [Index_Width-1:0]              Rsp_Index_1,
   output logic [Index_Width-1:0]              Rsp_Index_2,
   output logic [Index_Width-1:0]              Rsp_Index_3,
   input  logic                                Rsp_Ready_0,
   input  logic                                Rsp_Ready_1,
   input  logic                                Rsp_Ready_2,
   input  logic                                Rsp_Ready_3,
   output logic                                Ram_RE,
   output logic [Address_Width-1:0]            Ram_R_Add,
   input  logic [Data_Width+Index_Width-1:0]   Ram_R_Data,
   input  logic                                Alloc_Valid,
   input  logic [Address_Width-1:0]            Alloc_Add,
   output logic [Depth-1:0]                    Free_Mask,
   output logic                                Err_Alloc,
   output logic                                Err_Empty_Read
);

   logic [3:0]               req_valid, rsp_ready, eligible, grant, rsp_valid;
   logic [Address_Width-1:0] req_add [4];
   port_state_t              state_reg [4];
   port_state_t              state_next [4];
   logic [Data_Width-1:0]    rsp_data_reg [4];
   logic [Index_Width-1:0]   rsp_index_reg [4];
   logic [1:0]               ptr_reg, ptr_next, grant_idx;
   logic                     grant_any, slot_free, alloc_err;
   logic [Address_Width-1:0] sel_add;
   logic [Depth-1:0]         free_mask_reg, free_mask_next;
   logic                     empty_rd_reg, err_alloc_reg, err_empty_reg;

   assign req_valid  = {Req_Valid_3, Req_Valid_2, Req_Valid_1, Req_Valid_0};
   assign rsp_ready  = {Rsp_Ready_3, Rsp_Ready_2, Rsp_Ready_1, Rsp_Ready_0};
   assign req_add[0] = Req_Add_0;
   assign req_add[1] = Req_Add_1;
   assign req_add[2] = Req_Add_2;
   assign req_add[3] = Req_Add_3;

   // Only idle ports with a live request compete; nothing is granted while reset is held.
   always_comb begin
      for (int p = 0; p < 4; p++)
         eligible[p] = req_valid[p] && (state_reg[p] == IDLE) && rst_n;
   end

   rr_arbiter_4 u_arb (
      .req       (eligible),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any),
      .next_ptr  (ptr_next)
   );

   // A grant to a slot that is already free skips the RAM and returns a zero word.
   assign sel_add   = req_add[grant_idx];
   assign slot_free = free_mask_reg[sel_add];
   assign Ram_RE    = grant_any && !slot_free;
   assign Ram_R_Add = grant_any ? sel_add : '0;

   // Port state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 4; p++) state_reg[p] <= IDLE;
      end else begin
         for (int p = 0; p < 4; p++) state_reg[p] <= state_next[p];
      end
   end

   // Port next-state: grant -> one RAM latency cycle -> hold until the PE accepts
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         state_next[p] = state_reg[p];
         case (state_reg[p])
            IDLE:     if (grant[p]) state_next[p] = INFLIGHT;
            INFLIGHT: state_next[p] = HOLD;
            HOLD:     if (rsp_ready[p]) state_next[p] = IDLE;
            default:  state_next[p] = IDLE;
         endcase
      end
   end

   // Port outputs: the response is valid for exactly the HOLD state
   always_comb begin
      for (int p = 0; p < 4; p++) rsp_valid[p] = (state_reg[p] == HOLD);
   end

   // Capture the RAM word in the latency cycle; zero it when the slot was read empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 4; p++) begin
            rsp_data_reg[p]  <= '0;
            rsp_index_reg[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (state_reg[p] == INFLIGHT) begin
               rsp_data_reg[p]  <= empty_rd_reg ? '0 : Ram_R_Data[Data_Width-1:0];
               rsp_index_reg[p] <= empty_rd_reg ? '0 : Ram_R_Data[Data_Width +: Index_Width];
            end
         end
      end
   end

   // Free on grant, then allocation; an allocation into an occupied slot is only flagged
   always_comb begin
      free_mask_next = free_mask_reg;
      alloc_err      = Alloc_Valid && !free_mask_reg[Alloc_Add];
      if (grant_any) free_mask_next[sel_add] = 1'b1;
      if (Alloc_Valid && free_mask_reg[Alloc_Add]) free_mask_next[Alloc_Add] = 1'b0;
   end

   // Pointer, free mask and the one-cycle error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg       <= '0;
         free_mask_reg <= '1;
         empty_rd_reg  <= 1'b0;
         err_alloc_reg <= 1'b0;
         err_empty_reg <= 1'b0;
      end else begin
         ptr_reg       <= ptr_next;
         free_mask_reg <= free_mask_next;
         empty_rd_reg  <= grant_any && slot_free;
         err_alloc_reg <= alloc_err;
         err_empty_reg <= grant_any && slot_free;
      end
   end

   assign Req_Ready_0    = grant[0];
   assign Req_Ready_1    = grant[1];
   assign Req_Ready_2    = grant[2];
   assign Req_Ready_3    = grant[3];
   assign Rsp_Valid_0    = rsp_valid[0];
   assign Rsp_Valid_1    = rsp_valid[1];
   assign Rsp_Valid_2    = rsp_valid[2];
   assign Rsp_Valid_3    = rsp_valid[3];
   assign Rsp_Data_0     = rsp_data_reg[0];
   assign Rsp_Data_1     = rsp_data_reg[1];
   assign Rsp_Data_2     = rsp_data_reg[2];
   assign Rsp_Data_3     = rsp_data_reg[3];
   assign Rsp_Index_0    = rsp_index_reg[0];
   assign Rsp_Index_1    = rsp_index_reg[1];
   assign Rsp_Index_2    = rsp_index_reg[2];
   assign Rsp_Index_3    = rsp_index_reg[3];
   assign Free_Mask      = free_mask_reg;
   assign Err_Alloc      = err_alloc_reg;
   assign Err_Empty_Read = err_empty_reg;

endmodule
